pe_layer_ctrl: RTL and testbench

Timestep sequencer for one layer of `pe` processing elements. It accepts one input spike vector per timestep and scans it. For each active input it fetches that input's weight row from weight memory, broadcasts the row into the PE array and pulses accumulate. It then issues a single `spike_done` fire phase, captures the PE spike vector and returns it over a valid/ready handshake.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/pe_layer_ctrl_if.sv | 49 ++++
 rtl/pe_layer_ctrl.sv | 130 +++++++++++++
 tb/tb_pe_layer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types and defaults for the spiking-layer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

  localparam int WEIGHT_W_DEF = 8;

  // Controller phases for one timestep
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    LOAD  = 3'd2,
    ACCUM = 3'd3,
    FIRE  = 3'd4,
    OUT   = 3'd5
  } pe_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_layer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_layer_ctrl_if
// Description : Spike-vector handshakes, weight-memory port and PE-array
//               broadcast signals of the layer controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_layer_ctrl_if
  import snn_pkg::*;
#(
  parameter int N_IN     = 16,
  parameter int N_PE     = 8,
  parameter int WEIGHT_W = WEIGHT_W_DEF
);

  localparam int AW = $clog2(N_IN);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN-1:0]          in_spikes;
  logic                     wmem_rd_en;
  logic [AW-1:0]            wmem_addr;
  logic [N_PE*WEIGHT_W-1:0] wmem_data;
  logic                     pe_weight_w_en;
  logic [N_PE*WEIGHT_W-1:0] pe_weight;
  logic                     pe_accum_en;
  logic                     pe_spike_done;
  logic [N_PE-1:0]          pe_spike;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_PE-1:0]          out_spikes;
  logic                     busy;

  // Controller side
  modport master (
    input  in_valid, in_spikes, wmem_data, pe_spike, out_ready,
    output in_ready, wmem_rd_en, wmem_addr, pe_weight_w_en, pe_weight,
           pe_accum_en, pe_spike_done, out_valid, out_spikes, busy
  );

  // Environment side (source, weight memory, PE array, sink)
  modport slave (
    output in_valid, in_spikes, wmem_data, pe_spike, out_ready,
    input  in_ready, wmem_rd_en, wmem_addr, pe_weight_w_en, pe_weight,
           pe_accum_en, pe_spike_done, out_valid, out_spikes, busy
  );

endinterface
`default_nettype wire

// File: rtl/pe_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_layer_ctrl
// Description : Timestep sequencer for one layer of PEs. Scans a latched
//               input spike vector, loads and accumulates the weight row of
//               every active input, fires once and returns the spike vector.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_layer_ctrl
  import snn_pkg::*;
#(
  parameter int N_IN     = 16,
  parameter int N_PE     = 8,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  wire logic      clock,
  input  wire logic      reset,
  pe_layer_ctrl_if.master bus
);

  localparam int            AW     = $clog2(N_IN);
  localparam logic [AW-1:0] c_LAST = AW'(N_IN - 1);

  pe_ctrl_state_t           r_state;
  pe_ctrl_state_t           w_state_next;
  logic [AW-1:0]            r_idx;
  logic [AW-1:0]            w_idx_next;
  logic [N_IN-1:0]          r_vec;
  logic [N_PE-1:0]          r_out_spikes;
  logic                     w_accept;
  logic                     w_rd_en;
  logic                     w_weight_w_en;
  logic                     w_accum_en;
  logic                     w_spike_done;
  logic                     w_out_valid;
  logic [N_PE*WEIGHT_W-1:0] w_row;

  // Weight rows pass straight through to the PE array; no arithmetic here
  assign w_row         = bus.wmem_data;
  assign bus.pe_weight = w_row;

  // Accept is only possible in IDLE; reset masks in_ready
  assign w_accept = (r_state == IDLE) && bus.in_valid;

  // State, scan index, latched input vector and result register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_vec        <= '0;
      r_out_spikes <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_accept) begin
        r_vec <= bus.in_spikes;
      end
      if (r_state == FIRE) begin
        r_out_spikes <= bus.pe_spike;
      end
    end
  end

  // Next-state, index update and one-hot phase strobes
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_rd_en       = 1'b0;
    w_weight_w_en = 1'b0;
    w_accum_en    = 1'b0;
    w_spike_done  = 1'b0;
    w_out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SCAN;
          w_idx_next   = '0;
        end
      end
      SCAN: begin
        if (r_vec[r_idx]) begin
          w_rd_en      = 1'b1;
          w_state_next = LOAD;
        end else if (r_idx == c_LAST) begin
          w_state_next = FIRE;
        end else begin
          w_idx_next = r_idx + AW'(1);
        end
      end
      LOAD: begin
        w_weight_w_en = 1'b1;
        w_state_next  = ACCUM;
      end
      ACCUM: begin
        w_accum_en = 1'b1;
        if (r_idx == c_LAST) begin
          w_state_next = FIRE;
        end else begin
          w_idx_next   = r_idx + AW'(1);
          w_state_next = SCAN;
        end
      end
      FIRE: begin
        w_spike_done = 1'b1;
        w_state_next = OUT;
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready       = (r_state == IDLE) && !reset;
  assign bus.busy           = (r_state != IDLE);
  assign bus.wmem_rd_en     = w_rd_en;
  assign bus.wmem_addr      = r_idx;
  assign bus.pe_weight_w_en = w_weight_w_en;
  assign bus.pe_accum_en    = w_accum_en;
  assign bus.pe_spike_done  = w_spike_done;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_spikes     = r_out_spikes;

endmodule
`default_nettype wire

// File: tb/tb_pe_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_layer_ctrl
// Description : Directed bench for pe_layer_ctrl with a weight-memory model
//               and a small behavioural PE array (threshold 20, 8-bit wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_layer_ctrl;

  localparam int N_IN      = 4;
  localparam int N_PE      = 8;
  localparam int WEIGHT_W  = 8;
  localparam int THRESHOLD = 20;

  // Phase codes derived from the observable strobes
  localparam int K_IDLE  = 0;
  localparam int K_SCAN  = 1;
  localparam int K_LOAD  = 2;
  localparam int K_ACCUM = 3;
  localparam int K_FIRE  = 4;
  localparam int K_OUT   = 5;

  logic clock;
  logic reset;
  logic pe_clr;
  int   checks;
  int   failures;

  logic [N_PE*WEIGHT_W-1:0] rows [N_IN];
  logic [7:0]               pot  [N_PE];
  logic [7:0]               wreg [N_PE];

  pe_layer_ctrl_if #(.N_IN(N_IN), .N_PE(N_PE), .WEIGHT_W(WEIGHT_W)) bus ();

  pe_layer_ctrl #(.N_IN(N_IN), .N_PE(N_PE), .WEIGHT_W(WEIGHT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Weight memory: one-cycle read latency
  always @(posedge clock) begin
    if (bus.wmem_rd_en) bus.wmem_data <= rows[bus.wmem_addr];
  end

  // Behavioural PE array
  always_comb begin
    for (int k = 0; k < N_PE; k++) bus.pe_spike[k] = (pot[k] > 8'(THRESHOLD));
  end

  always @(posedge clock) begin
    for (int k = 0; k < N_PE; k++) begin
      if (pe_clr) begin
        pot[k]  <= 8'd0;
        wreg[k] <= 8'd0;
      end else begin
        if (bus.pe_weight_w_en) wreg[k] <= bus.pe_weight[8*k +: 8];
        if (bus.pe_accum_en) pot[k] <= pot[k] + wreg[k];
        else if (bus.pe_spike_done && bus.pe_spike[k]) pot[k] <= 8'd0;
      end
    end
  end

  function automatic int classify();
    if (!bus.busy)               return K_IDLE;
    else if (bus.pe_weight_w_en) return K_LOAD;
    else if (bus.pe_accum_en)    return K_ACCUM;
    else if (bus.pe_spike_done)  return K_FIRE;
    else if (bus.out_valid)      return K_OUT;
    else                         return K_SCAN;
  endfunction

  function automatic logic [63:0] pots();
    logic [63:0] v;
    for (int k = 0; k < N_PE; k++) v[8*k +: 8] = pot[k];
    return v;
  endfunction

  task automatic clear_pes();
    @(negedge clock); pe_clr = 1'b1;
    @(negedge clock); pe_clr = 1'b0;
  endtask

  task automatic set_rows_3k();
    for (int r = 0; r < N_IN; r++)
      for (int k = 0; k < N_PE; k++) rows[r][8*k +: 8] = 8'(3 * k);
  endtask

  // Present a vector at a negedge; returns just after the accept edge
  task automatic start_vector(input logic [N_IN-1:0] vec, input bit hold);
    @(negedge clock);
    bus.in_spikes = vec;
    bus.in_valid  = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++;
    if ({bus.busy, bus.out_valid, bus.wmem_rd_en, bus.pe_weight_w_en, bus.pe_accum_en, bus.pe_spike_done} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000",
        {bus.busy, bus.out_valid, bus.wmem_rd_en, bus.pe_weight_w_en, bus.pe_accum_en, bus.pe_spike_done});
    end
    checks++;
    if (bus.out_spikes !== 8'h00 || bus.wmem_addr !== 2'd0) begin
      failures++; $display("FAIL reset_regs out_spikes=%h addr=%0d exp=00/0", bus.out_spikes, bus.wmem_addr);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int exp_seq [10] = '{K_SCAN, K_LOAD, K_ACCUM, K_SCAN, K_SCAN, K_LOAD, K_ACCUM, K_SCAN, K_FIRE, K_OUT};
    int rd = 0;
    int code;
    for (int r = 0; r < N_IN; r++) rows[r] = '0;
    rows[0] = {8{8'd5}};
    rows[2] = {8{8'd20}};
    clear_pes();
    start_vector(4'b0101, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      code = classify();
      if (bus.wmem_rd_en) rd++;
      checks++;
      if (code !== exp_seq[c]) begin failures++; $display("FAIL basic_phase cycle=%0d got=%0d exp=%0d", c, code, exp_seq[c]); end
    end
    checks++;
    if (bus.out_spikes !== 8'hFF) begin failures++; $display("FAIL basic_out_spikes got=%h exp=ff", bus.out_spikes); end
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_return busy=%b in_ready=%b exp=0/1", bus.busy, bus.in_ready);
    end
    checks++;
    if (rd !== 2) begin failures++; $display("FAIL basic_rd_count got=%0d exp=2", rd); end
    checks++;
    if (pots() !== 64'h0) begin failures++; $display("FAIL basic_pots got=%h exp=0", pots()); end
  endtask

  task automatic test_zero_vector();
    int exp_seq [6] = '{K_SCAN, K_SCAN, K_SCAN, K_SCAN, K_FIRE, K_OUT};
    int pulses = 0;
    int code;
    start_vector(4'b0000, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      code = classify();
      if (bus.wmem_rd_en || bus.pe_weight_w_en || bus.pe_accum_en) pulses++;
      checks++;
      if (code !== exp_seq[c]) begin failures++; $display("FAIL zero_phase cycle=%0d got=%0d exp=%0d", c, code, exp_seq[c]); end
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL zero_pulses got=%0d exp=0", pulses); end
    checks++;
    if (bus.out_spikes !== 8'h00) begin failures++; $display("FAIL zero_out_spikes got=%h exp=00", bus.out_spikes); end
    @(negedge clock);
  endtask

  task automatic test_all_ones();
    int code;
    int exp_code;
    set_rows_3k();
    start_vector(4'b1111, 1'b0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      code = classify();
      exp_code = (c == 13) ? K_OUT : (c == 12) ? K_FIRE : (c % 3 == 0) ? K_SCAN : (c % 3 == 1) ? K_LOAD : K_ACCUM;
      checks++;
      if (code !== exp_code) begin failures++; $display("FAIL ones_phase cycle=%0d got=%0d exp=%0d", c, code, exp_code); end
    end
    checks++;
    if (bus.out_spikes !== 8'hFC) begin failures++; $display("FAIL ones_out_spikes got=%h exp=fc", bus.out_spikes); end
    @(negedge clock);
    checks++;
    if (pots() !== 64'h0000_0000_0000_0C00) begin
      failures++; $display("FAIL ones_pots got=%h exp=0000000000000c00", pots());
    end
  endtask

  task automatic test_out_hold();
    int found = 0;
    bus.out_ready = 1'b0;
    start_vector(4'b0001, 1'b0);
    for (int c = 0; c < 30 && found == 0; c++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        found = 1;
        checks++;
        if (c !== 7) begin failures++; $display("FAIL hold_latency got=%0d exp=7", c); end
      end
    end
    if (found == 0) begin
      checks++; failures++; $display("FAIL hold_timeout got=no_out_valid exp=out_valid");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_spikes !== 8'h80 || bus.in_ready !== 1'b0 ||
          {bus.pe_weight_w_en, bus.pe_accum_en, bus.pe_spike_done} !== 3'b0) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d got valid=%b spikes=%h in_ready=%b strobes=%b exp 1/80/0/000",
                 c, bus.out_valid, bus.out_spikes, bus.in_ready,
                 {bus.pe_weight_w_en, bus.pe_accum_en, bus.pe_spike_done});
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release busy=%b in_ready=%b exp=0/1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int exp_seq [8] = '{K_SCAN, K_SCAN, K_SCAN, K_LOAD, K_ACCUM, K_SCAN, K_FIRE, K_OUT};
    int found = 0;
    int code;
    start_vector(4'b1111, 1'b0);
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clock);
      if (bus.pe_accum_en) found = 1;
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL midrst_no_accum got=none exp=accum"); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.busy, bus.out_valid, bus.wmem_rd_en, bus.pe_weight_w_en, bus.pe_accum_en, bus.pe_spike_done} !== 6'b0) begin
      failures++; $display("FAIL midrst_strobes got=%b exp=000000",
        {bus.busy, bus.out_valid, bus.wmem_rd_en, bus.pe_weight_w_en, bus.pe_accum_en, bus.pe_spike_done});
    end
    reset = 1'b0;
    clear_pes();
    start_vector(4'b0100, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      code = classify();
      checks++;
      if (code !== exp_seq[c]) begin failures++; $display("FAIL midrst_phase cycle=%0d got=%0d exp=%0d", c, code, exp_seq[c]); end
    end
    checks++;
    if (bus.out_spikes !== 8'h80) begin failures++; $display("FAIL midrst_out_spikes got=%h exp=80", bus.out_spikes); end
    @(negedge clock);
  endtask

  task automatic test_latch();
    int exp_seq [8] = '{K_SCAN, K_LOAD, K_ACCUM, K_SCAN, K_SCAN, K_SCAN, K_FIRE, K_OUT};
    int code;
    start_vector(4'b0001, 1'b1);
    bus.in_spikes = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      code = classify();
      checks++;
      if (code !== exp_seq[c] || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL latch_phase cycle=%0d got=%0d in_ready=%b exp=%0d/0", c, code, bus.in_ready, exp_seq[c]);
      end
    end
    checks++;
    if (bus.out_spikes !== 8'hF0) begin failures++; $display("FAIL latch_out_spikes got=%h exp=f0", bus.out_spikes); end
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL latch_return busy=%b in_ready=%b exp=0/1", bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    pe_clr        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_spikes = '0;
    bus.out_ready = 1'b1;
    bus.wmem_data = '0;
    for (int k = 0; k < N_PE; k++) begin
      pot[k]  = 8'd0;
      wreg[k] = 8'd0;
    end
    for (int r = 0; r < N_IN; r++) rows[r] = '0;

    test_reset();
    test_basic();
    test_zero_vector();
    test_all_ones();
    test_out_hold();
    test_reset_mid();
    test_latch();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
